// File: rtl/atp_pay_sequencer.sv
// Session sequencer for the ATP bill-payment kiosk: auth, bill fetch, charges, method, tender, commit, receipt.
// Latency: one clock per state transition; every output is registered (visible the cycle after the deciding edge).
// Backpressure: none; the front end holds each *_valid one cycle and may retry; wait states time out.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge) and asynchronous active-low reset
//   i_exit                customer abort; honoured in VALIDATE..OLD_BALANCE, ignored while committing
//   i_start, i_consumer_num  session start; consumer number latched when the start is accepted
//   i_auth_valid, i_auth_hash, i_ref_hash  scanned hash and stored hash for the latched consumer
//   i_bill_amt            outstanding bill, sampled in BILL_PAYMENT
//   i_method_valid, i_pay_method  payment method (0 cash, 1 cheque/DD)
//   i_tender_valid, i_tender_amt  amount tendered
//   o_state               current FSM state encoding
//   o_cons_id, o_charges, o_balance  session data; held after a completed session
//   o_error               one-cycle pulse on any rejected action, timeout or bill of zero
//   o_locked              sticky lockout after MAX_TRIES consecutive hash mismatches
//   o_txn_commit          one-cycle pulse, high while in TRANSACTION
//   o_receipt_valid       one-cycle pulse, high while in RECEIPT

module atp_pay_sequencer #(
    parameter int AMT_W       = 11,
    parameter int HASH_W      = 8,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 255,
    parameter int FEE_CHEQUE  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_exit,
    input  logic              i_start,
    input  logic [3:0]        i_consumer_num,
    input  logic              i_auth_valid,
    input  logic [HASH_W-1:0] i_auth_hash,
    input  logic [HASH_W-1:0] i_ref_hash,
    input  logic [AMT_W-1:0]  i_bill_amt,
    input  logic              i_method_valid,
    input  logic              i_pay_method,
    input  logic              i_tender_valid,
    input  logic [AMT_W-1:0]  i_tender_amt,
    output logic [2:0]        o_state,
    output logic [3:0]        o_cons_id,
    output logic [AMT_W-1:0]  o_charges,
    output logic [AMT_W-1:0]  o_balance,
    output logic              o_error,
    output logic              o_locked,
    output logic              o_txn_commit,
    output logic              o_receipt_valid
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [AMT_W:0]   FEE_EXT  = (AMT_W + 1)'(FEE_CHEQUE);

    typedef enum logic [2:0] {
        ST_INPUT_METHOD   = 3'b000,
        ST_VALIDATE       = 3'b001,
        ST_BILL_PAYMENT   = 3'b010,
        ST_CHARGES        = 3'b011,
        ST_PAYMENT_METHOD = 3'b100,
        ST_OLD_BALANCE    = 3'b101,
        ST_TRANSACTION    = 3'b110,
        ST_RECEIPT        = 3'b111
    } state_t;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [TRY_W-1:0]   r_tries;
    logic [TMO_W-1:0]   r_tmo;
    logic [AMT_W-1:0]   r_bill;
    logic [3:0]         r_cons_id;
    logic [AMT_W-1:0]   r_charges;
    logic [AMT_W-1:0]   r_balance;
    logic               r_error;
    logic               r_locked;
    logic               r_txn_commit;
    logic               r_receipt_valid;

    // Next-state values
    state_t             w_state;
    logic [TRY_W-1:0]   w_tries;
    logic [TMO_W-1:0]   w_tmo;
    logic [AMT_W-1:0]   w_bill;
    logic [3:0]         w_cons_id;
    logic [AMT_W-1:0]   w_charges;
    logic [AMT_W-1:0]   w_balance;
    logic               w_error;
    logic               w_locked;
    logic               w_txn_commit;
    logic               w_receipt_valid;
    logic               w_abort;

    // Helper terms
    logic               w_any_valid;
    logic               w_wait_state;
    logic               w_tmo_hit;
    logic               w_hash_match;
    logic [AMT_W:0]     w_fee_sum;
    logic [AMT_W-1:0]   w_charges_fee;
    logic               w_tender_bad;

    assign w_any_valid  = i_auth_valid | i_method_valid | i_tender_valid;
    assign w_wait_state = (r_state == ST_VALIDATE) ||
                          (r_state == ST_PAYMENT_METHOD) ||
                          (r_state == ST_OLD_BALANCE);
    // The idle counter holds the number of completed idle cycles in this
    // state, so the TIMEOUT_CYC-th consecutive idle cycle is the one that fires.
    assign w_tmo_hit    = w_wait_state && !w_any_valid && (r_tmo == TMO_LAST);
    assign w_hash_match = (i_auth_hash == i_ref_hash);

    // Cheque surcharge computed one bit wider so overflow can saturate.
    assign w_fee_sum     = {1'b0, r_charges} + FEE_EXT;
    assign w_charges_fee = w_fee_sum[AMT_W] ? {AMT_W{1'b1}} : w_fee_sum[AMT_W-1:0];

    assign w_tender_bad  = (i_tender_amt == '0) || (i_tender_amt > r_charges);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state         = r_state;
        w_tries         = r_tries;
        w_bill          = r_bill;
        w_cons_id       = r_cons_id;
        w_charges       = r_charges;
        w_balance       = r_balance;
        w_error         = 1'b0;
        w_locked        = r_locked;
        w_txn_commit    = 1'b0;
        w_receipt_valid = 1'b0;
        w_abort         = 1'b0;

        unique case (r_state)
            ST_INPUT_METHOD: begin
                if (i_start) begin
                    if (r_locked) begin
                        w_error = 1'b1;
                    end else if (!i_exit) begin
                        w_state   = ST_VALIDATE;
                        w_cons_id = i_consumer_num;
                        w_charges = '0;
                        w_balance = '0;
                    end
                end
            end

            ST_VALIDATE: begin
                if (i_exit) begin
                    w_abort = 1'b1;
                end else if (i_auth_valid) begin
                    if (w_hash_match) begin
                        w_state = ST_BILL_PAYMENT;
                        w_tries = '0;
                    end else begin
                        w_error = 1'b1;
                        w_tries = r_tries + 1'b1;
                        if (r_tries == TRY_LAST) begin
                            w_locked = 1'b1;
                            w_abort  = 1'b1;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_error = 1'b1;
                    w_abort = 1'b1;
                end
            end

            ST_BILL_PAYMENT: begin
                if (i_exit) begin
                    w_abort = 1'b1;
                end else if (i_bill_amt == '0) begin
                    w_error = 1'b1;
                    w_abort = 1'b1;
                end else begin
                    w_bill  = i_bill_amt;
                    w_state = ST_CHARGES;
                end
            end

            ST_CHARGES: begin
                if (i_exit) begin
                    w_abort = 1'b1;
                end else begin
                    w_charges = r_bill;
                    w_state   = ST_PAYMENT_METHOD;
                end
            end

            ST_PAYMENT_METHOD: begin
                if (i_exit) begin
                    w_abort = 1'b1;
                end else if (i_method_valid) begin
                    if (i_pay_method) begin
                        w_charges = w_charges_fee;
                    end
                    w_state = ST_OLD_BALANCE;
                end else if (w_tmo_hit) begin
                    w_error = 1'b1;
                    w_abort = 1'b1;
                end
            end

            ST_OLD_BALANCE: begin
                if (i_exit) begin
                    w_abort = 1'b1;
                end else if (i_tender_valid) begin
                    if (w_tender_bad) begin
                        w_error = 1'b1;
                    end else begin
                        w_balance    = r_charges - i_tender_amt;
                        w_state      = ST_TRANSACTION;
                        // Registered so the pulse coincides with TRANSACTION.
                        w_txn_commit = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_error = 1'b1;
                    w_abort = 1'b1;
                end
            end

            // Commit and receipt are atomic: exit is not looked at here.
            ST_TRANSACTION: begin
                w_state         = ST_RECEIPT;
                w_receipt_valid = 1'b1;
            end

            ST_RECEIPT: begin
                w_state = ST_INPUT_METHOD;
            end

            default: begin
                w_state = ST_INPUT_METHOD;
            end
        endcase

        // Any return to idle other than through RECEIPT discards the session.
        if (w_abort) begin
            w_state   = ST_INPUT_METHOD;
            w_cons_id = '0;
            w_charges = '0;
            w_balance = '0;
            w_bill    = '0;
        end
    end

    // Idle counter: restarts on entry to a state and on any valid.
    always_comb begin
        w_tmo = '0;
        if (w_wait_state && (w_state == r_state) && !w_any_valid) begin
            w_tmo = r_tmo + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_INPUT_METHOD;
            r_tries         <= '0;
            r_tmo           <= '0;
            r_bill          <= '0;
            r_cons_id       <= '0;
            r_charges       <= '0;
            r_balance       <= '0;
            r_error         <= 1'b0;
            r_locked        <= 1'b0;
            r_txn_commit    <= 1'b0;
            r_receipt_valid <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_tries         <= w_tries;
            r_tmo           <= w_tmo;
            r_bill          <= w_bill;
            r_cons_id       <= w_cons_id;
            r_charges       <= w_charges;
            r_balance       <= w_balance;
            r_error         <= w_error;
            r_locked        <= w_locked;
            r_txn_commit    <= w_txn_commit;
            r_receipt_valid <= w_receipt_valid;
        end
    end

    assign o_state         = r_state;
    assign o_cons_id       = r_cons_id;
    assign o_charges       = r_charges;
    assign o_balance       = r_balance;
    assign o_error         = r_error;
    assign o_locked        = r_locked;
    assign o_txn_commit    = r_txn_commit;
    assign o_receipt_valid = r_receipt_valid;

endmodule

// File: tb/tb_atp_pay_sequencer.sv
// Bench for atp_pay_sequencer: session-level reference model checked every cycle plus literal checkpoints.
// Latency: model is updated on the same clock edge as the DUT and compared on the falling edge.
// Backpressure: not applicable; stimulus is directed and every wait is a fixed cycle count.

module tb_atp_pay_sequencer;

    localparam int TIMEOUT_CYC = 255;
    localparam int MAX_TRIES   = 3;
    localparam int FEE         = 5;
    localparam int AMT_MAX     = 2047;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        exit_i = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cnum = 4'd0;
    logic        auth_v = 1'b0;
    logic [7:0]  auth_h = 8'd0;
    logic [7:0]  ref_h = 8'hED;
    logic [10:0] bill = 11'd0;
    logic        meth_v = 1'b0;
    logic        meth = 1'b0;
    logic        ten_v = 1'b0;
    logic [10:0] ten = 11'd0;

    logic [2:0]  st;
    logic [3:0]  cons;
    logic [10:0] chg;
    logic [10:0] bal;
    logic        err;
    logic        lck;
    logic        com;
    logic        rcp;

    int n_tests = 0;
    int n_fail  = 0;

    atp_pay_sequencer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_exit          (exit_i),
        .i_start         (start),
        .i_consumer_num  (cnum),
        .i_auth_valid    (auth_v),
        .i_auth_hash     (auth_h),
        .i_ref_hash      (ref_h),
        .i_bill_amt      (bill),
        .i_method_valid  (meth_v),
        .i_pay_method    (meth),
        .i_tender_valid  (ten_v),
        .i_tender_amt    (ten),
        .o_state         (st),
        .o_cons_id       (cons),
        .o_charges       (chg),
        .o_balance       (bal),
        .o_error         (err),
        .o_locked        (lck),
        .o_txn_commit    (com),
        .o_receipt_valid (rcp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Session model: phase numbers follow the published state codes.
    // ------------------------------------------------------------------
    int m_phase   = 0;
    int m_tries   = 0;
    int m_idle    = 0;
    int m_bill    = 0;
    int m_cons    = 0;
    int m_charges = 0;
    int m_balance = 0;
    bit m_err     = 0;
    bit m_locked  = 0;
    bit m_commit  = 0;
    bit m_rcpt    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_tries = 0; m_idle = 0; m_bill = 0; m_cons = 0;
            m_charges = 0; m_balance = 0; m_err = 0; m_locked = 0; m_commit = 0; m_rcpt = 0;
        end else begin
            int  nxt;
            bit  abort;
            bit  anyv;
            nxt   = m_phase;
            abort = 0;
            anyv  = auth_v | meth_v | ten_v;
            m_err = 0; m_commit = 0; m_rcpt = 0;
            if (m_phase >= 1 && m_phase <= 5 && exit_i) begin
                abort = 1;
            end else begin
                case (m_phase)
                    0: if (start) begin
                        if (m_locked) m_err = 1;
                        else if (!exit_i) begin
                            nxt = 1; m_cons = int'(cnum); m_charges = 0; m_balance = 0;
                        end
                    end
                    1: if (auth_v) begin
                        if (auth_h == ref_h) begin nxt = 2; m_tries = 0; end
                        else begin
                            m_err = 1; m_tries++;
                            if (m_tries >= MAX_TRIES) begin m_locked = 1; abort = 1; end
                        end
                    end
                    2: if (bill == 0) begin m_err = 1; abort = 1; end
                       else begin m_bill = int'(bill); nxt = 3; end
                    3: begin m_charges = m_bill; nxt = 4; end
                    4: if (meth_v) begin
                        if (meth) m_charges = (m_charges + FEE > AMT_MAX) ? AMT_MAX : m_charges + FEE;
                        nxt = 5;
                    end
                    5: if (ten_v) begin
                        if (ten == 0 || int'(ten) > m_charges) m_err = 1;
                        else begin m_balance = m_charges - int'(ten); nxt = 6; m_commit = 1; end
                    end
                    6: begin nxt = 7; m_rcpt = 1; end
                    default: nxt = 0;
                endcase
                // Timeout: count consecutive idle cycles in the three wait phases.
                if ((m_phase == 1 || m_phase == 4 || m_phase == 5) && nxt == m_phase && !abort) begin
                    if (anyv) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == TIMEOUT_CYC) begin m_err = 1; abort = 1; end
                    end
                end
            end
            if (abort) begin
                nxt = 0; m_cons = 0; m_charges = 0; m_balance = 0; m_bill = 0;
            end
            if (nxt != m_phase) m_idle = 0;
            m_phase = nxt;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state",   32'(st),  32'(m_phase));
            chk("cons_id", 32'(cons), 32'(m_cons));
            chk("charges", 32'(chg), 32'(m_charges));
            chk("balance", 32'(bal), 32'(m_balance));
            chk("error",   32'(err), 32'(m_err));
            chk("locked",  32'(lck), 32'(m_locked));
            chk("commit",  32'(com), 32'(m_commit));
            chk("receipt", 32'(rcp), 32'(m_rcpt));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: each call advances one edge, then clears pulses.
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [3:0] n);
        start = 1'b1; cnum = n; step(); start = 1'b0;
    endtask

    task automatic do_auth(input logic [7:0] h);
        auth_v = 1'b1; auth_h = h; step(); auth_v = 1'b0;
    endtask

    task automatic do_method(input logic m);
        meth_v = 1'b1; meth = m; step(); meth_v = 1'b0;
    endtask

    task automatic do_tender(input logic [10:0] a);
        ten_v = 1'b1; ten = a; step(); ten_v = 1'b0;
    endtask

    // Start, authenticate and fetch a bill; ends in PAYMENT_METHOD.
    task automatic to_method(input logic [3:0] n, input logic [10:0] b);
        do_start(n);
        do_auth(8'hED);
        bill = b;
        step(2);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(2);
        chk("rst_state",  32'(st), 32'd0);
        chk("rst_locked", 32'(lck), 32'd0);
        chk("rst_commit", 32'(com), 32'd0);
        rst_n = 1'b1;
        step();

        // Happy path, cash, exact tender
        do_start(4'd3);
        chk("t1_validate", 32'(st), 32'd1);
        do_auth(8'hED);
        chk("t1_bill_state", 32'(st), 32'd2);
        bill = 11'd100;
        step(2);
        chk("t1_charges", 32'(chg), 32'd100);
        do_method(1'b0);
        chk("t1_old_bal", 32'(st), 32'd5);
        do_tender(11'd100);
        chk("t1_commit", 32'(com), 32'd1);
        chk("t1_balance", 32'(bal), 32'd0);
        step();
        chk("t1_receipt", 32'(rcp), 32'd1);
        chk("t1_commit_gone", 32'(com), 32'd0);
        step();
        chk("t1_idle", 32'(st), 32'd0);
        chk("t1_cons_held", 32'(cons), 32'd3);

        // Cheque with saturating surcharge; exit ignored while committing
        to_method(4'd5, 11'd2045);
        do_method(1'b1);
        chk("t3_sat", 32'(chg), 32'd2047);
        do_tender(11'd2000);
        chk("t3_balance", 32'(bal), 32'd47);
        chk("t3_commit", 32'(com), 32'd1);
        exit_i = 1'b1; step(); exit_i = 1'b0;
        chk("t3_exit_ignored", 32'(st), 32'd7);
        step();

        // Over-tender and zero tender rejected, then partial payment
        to_method(4'd7, 11'd50);
        do_method(1'b0);
        do_tender(11'd60);
        chk("t4_over_err", 32'(err), 32'd1);
        chk("t4_over_stay", 32'(st), 32'd5);
        do_tender(11'd0);
        chk("t4_zero_err", 32'(err), 32'd1);
        do_tender(11'd30);
        chk("t4_balance", 32'(bal), 32'd20);
        chk("t4_txn", 32'(st), 32'd6);
        step(2);

        // Exit beats same-cycle method_valid
        to_method(4'd9, 11'd70);
        exit_i = 1'b1; meth_v = 1'b1; meth = 1'b1;
        step();
        exit_i = 1'b0; meth_v = 1'b0;
        chk("t5_exit_idle", 32'(st), 32'd0);
        chk("t5_exit_noerr", 32'(err), 32'd0);
        chk("t5_exit_clr", 32'(cons), 32'd0);

        // Auth timeout
        do_start(4'd6);
        step(TIMEOUT_CYC - 1);
        chk("t5_tmo_not_yet", 32'(st), 32'd1);
        step();
        chk("t5_tmo_idle", 32'(st), 32'd0);
        chk("t5_tmo_err", 32'(err), 32'd1);

        // Zero bill
        do_start(4'd2);
        do_auth(8'hED);
        bill = 11'd0;
        step();
        chk("zero_bill_err", 32'(err), 32'd1);
        chk("zero_bill_idle", 32'(st), 32'd0);

        // Lockout after three mismatches
        do_start(4'd1);
        do_auth(8'h96);
        chk("t2_err1", 32'(err), 32'd1);
        do_auth(8'hB2);
        chk("t2_stay", 32'(st), 32'd1);
        do_auth(8'h96);
        chk("t2_locked", 32'(lck), 32'd1);
        chk("t2_idle", 32'(st), 32'd0);
        do_start(4'd2);
        chk("t2_start_err", 32'(err), 32'd1);
        chk("t2_start_idle", 32'(st), 32'd0);

        rst_n = 1'b0;
        step();
        chk("unlock", 32'(lck), 32'd0);
        rst_n = 1'b1;
        step();

        // Async reset in TRANSACTION
        to_method(4'd4, 11'd10);
        do_method(1'b0);
        do_tender(11'd10);
        chk("t6_in_txn", 32'(st), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_state", 32'(st), 32'd0);
        chk("t6_async_commit", 32'(com), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
